// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants and state encoding for the 4-channel round-robin arbiter
//
// Purpose : channel count, select width and FSM state encoding used by
//           arb_rr4_stream and its rotate-priority picker rr_pick4.
// Ports   : none (package)

package arb_pkg;

  localparam int NCH  = 4;  // number of input channels
  localparam int SELW = 2;  // width of a channel index / mux select

  // ARB  : free to pick a new channel each beat
  // HOLD : a multi-beat packet owns the grant until its last beat is taken
  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational rotate-priority encoder over four requests
//
// Purpose : returns the first asserted request found when scanning
//           ptr_i, ptr_i+1, ptr_i+2, ptr_i+3 (mod 4).
// Ports   : vld_i [NCH-1:0]  request vector
//           ptr_i [SELW-1:0] index with highest priority this cycle
//           hit_o            at least one request asserted
//           idx_o [SELW-1:0] index of the chosen request (ptr_i when no hit)

module rr_pick4
  import arb_pkg::*;
(
  input  logic [NCH-1:0]  vld_i,
  input  logic [SELW-1:0] ptr_i,
  output logic            hit_o,
  output logic [SELW-1:0] idx_o
);

  logic [SELW-1:0] cand;

  // Scan from the farthest offset down to offset 0 so that the candidate
  // closest to ptr_i is the last one written and therefore wins.
  always_comb begin
    hit_o = 1'b0;
    idx_o = ptr_i;
    cand  = ptr_i;
    for (int k = NCH - 1; k >= 0; k--) begin
      cand = ptr_i + SELW'(k);
      if (vld_i[cand]) begin
        hit_o = 1'b1;
        idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/arb_rr4_stream.sv
// rtl/arb_rr4_stream.sv - 4-channel valid/ready round-robin arbiter with packet lock and registered output
//
// Purpose : picks one of four input streams, locks onto it for the rest of a
//           multi-beat packet, and delivers one registered beat per cycle.
// Ports   : clk                 rising-edge clock
//           rst                 asynchronous active-high reset
//           in_vld  [3:0]       per-channel beat valid
//           in_lst  [3:0]       per-channel last-beat flag (qualified by in_vld)
//           in_rdy  [3:0]       per-channel accept, combinational, one-hot or zero
//           in_dat0..in_dat3    per-channel data
//           out_vld             registered output valid
//           out_rdy             consumer accept
//           out_dat [WIDTH-1:0] registered output data
//           out_lst             registered last flag
//           out_sel [1:0]       registered index of the channel behind out_dat

module arb_rr4_stream
  import arb_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   in_vld,
  input  logic [NCH-1:0]   in_lst,
  output logic [NCH-1:0]   in_rdy,
  input  logic [WIDTH-1:0] in_dat0,
  input  logic [WIDTH-1:0] in_dat1,
  input  logic [WIDTH-1:0] in_dat2,
  input  logic [WIDTH-1:0] in_dat3,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat,
  output logic             out_lst,
  output logic [SELW-1:0]  out_sel
);

  state_e          state_q, state_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [SELW-1:0] own_q, own_d;

  logic             out_vld_q, out_vld_d;
  logic [WIDTH-1:0] out_dat_q, out_dat_d;
  logic             out_lst_q, out_lst_d;
  logic [SELW-1:0]  out_sel_q, out_sel_d;

  logic             pick_hit;
  logic [SELW-1:0]  pick_idx;
  logic             win_hit;
  logic [SELW-1:0]  win_idx;
  logic             ld;
  logic             grant;
  logic             sel_lst;
  logic [WIDTH-1:0] sel_dat;

  rr_pick4 u_pick (
    .vld_i (in_vld),
    .ptr_i (ptr_q),
    .hit_o (pick_hit),
    .idx_o (pick_idx)
  );

  // Winner, accept and data selection.
  always_comb begin
    // Output register can take a beat when empty or being drained this cycle.
    ld = ~out_vld_q | out_rdy;

    // While locked, only the owner may be granted; others stall even if valid.
    if (state_q == ST_HOLD) begin
      win_idx = own_q;
      win_hit = in_vld[own_q];
    end else begin
      win_idx = pick_idx;
      win_hit = pick_hit;
    end

    grant  = ld & win_hit;
    in_rdy = '0;
    if (grant) begin
      in_rdy[win_idx] = 1'b1;
    end

    sel_lst = in_lst[win_idx];
    case (win_idx)
      2'd0:    sel_dat = in_dat0;
      2'd1:    sel_dat = in_dat1;
      2'd2:    sel_dat = in_dat2;
      default: sel_dat = in_dat3;
    endcase
  end

  // FSM next state and pointer/owner updates.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    if (grant) begin
      if (sel_lst) begin
        // Packet complete: the channel after the winner gets first look next time.
        state_d = ST_ARB;
        ptr_d   = win_idx + 2'd1;
      end else begin
        state_d = ST_HOLD;
        own_d   = win_idx;
      end
    end
  end

  // Output register next state.
  always_comb begin
    out_vld_d = out_vld_q;
    out_dat_d = out_dat_q;
    out_lst_d = out_lst_q;
    out_sel_d = out_sel_q;
    if (grant) begin
      out_vld_d = 1'b1;
      out_dat_d = sel_dat;
      out_lst_d = sel_lst;
      out_sel_d = win_idx;
    end else if (out_rdy) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_ARB;
      ptr_q     <= '0;
      own_q     <= '0;
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      out_lst_q <= 1'b0;
      out_sel_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      own_q     <= own_d;
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
      out_lst_q <= out_lst_d;
      out_sel_q <= out_sel_d;
    end
  end

  assign out_vld = out_vld_q;
  assign out_dat = out_dat_q;
  assign out_lst = out_lst_q;
  assign out_sel = out_sel_q;

endmodule

// File: tb/tb_arb_rr4_stream.sv
// tb/tb_arb_rr4_stream.sv - self-checking bench for arb_rr4_stream with a behavioural reference model

module tb_arb_rr4_stream;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   in_vld = '0;
  logic [3:0]   in_lst = '0;
  logic [3:0]   in_rdy;
  logic [W-1:0] dat [4];
  logic [W-1:0] in_dat0, in_dat1, in_dat2, in_dat3;
  logic         out_vld;
  logic         out_rdy = 1'b0;
  logic [W-1:0] out_dat;
  logic         out_lst;
  logic [1:0]   out_sel;

  assign in_dat0 = dat[0];
  assign in_dat1 = dat[1];
  assign in_dat2 = dat[2];
  assign in_dat3 = dat[3];

  always #5 clk = ~clk;

  arb_rr4_stream #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (in_vld),
    .in_lst  (in_lst),
    .in_rdy  (in_rdy),
    .in_dat0 (in_dat0),
    .in_dat1 (in_dat1),
    .in_dat2 (in_dat2),
    .in_dat3 (in_dat3),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .out_dat (out_dat),
    .out_lst (out_lst),
    .out_sel (out_sel)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who is next in line, whether a packet holds the grant,
  // and what the consumer should currently see.
  int           next_first = 0;
  bit           locked     = 1'b0;
  int           lock_ch    = 0;
  bit           m_vld      = 1'b0;
  logic [W-1:0] m_dat      = '0;
  bit           m_lst      = 1'b0;
  int           m_sel      = 0;

  function automatic int m_winner();
    int c;
    if (locked) return in_vld[lock_ch] ? lock_ch : -1;
    for (int k = 0; k < 4; k++) begin
      c = (next_first + k) % 4;
      if (in_vld[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] m_rdy();
    int w;
    w = m_winner();
    if ((!m_vld || out_rdy) && w >= 0) return 4'b0001 << w;
    return 4'b0000;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      next_first = 0;
      locked     = 1'b0;
      lock_ch    = 0;
      m_vld      = 1'b0;
      m_dat      = '0;
      m_lst      = 1'b0;
      m_sel      = 0;
    end else begin
      int w;
      logic [3:0] r;
      r = m_rdy();
      w = m_winner();
      if (r != 4'b0000) begin
        m_vld = 1'b1;
        m_dat = dat[w];
        m_lst = in_lst[w];
        m_sel = w;
        if (in_lst[w]) begin
          locked     = 1'b0;
          next_first = (w + 1) % 4;
        end else begin
          locked  = 1'b1;
          lock_ch = w;
        end
      end else if (out_rdy) begin
        m_vld = 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("m_in_rdy",  in_rdy,  m_rdy());
    chk("m_out_vld", out_vld, m_vld);
    chk("m_out_dat", out_dat, m_dat);
    chk("m_out_lst", out_lst, m_lst);
    chk("m_out_sel", out_sel, m_sel);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] t1_rdy [5];
  logic [3:0] acc;

  initial begin
    t1_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 4; i++) dat[i] = W'(16'h1000 + i);

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_dat", out_dat, 0);
    chk("rst_out_lst", out_lst, 0);
    chk("rst_out_sel", out_sel, 0);
    chk("rst_in_rdy",  in_rdy,  0);
    rst = 1'b0;
    step();

    // 1: all valid single-beat packets rotate 0,1,2,3,0
    in_vld = 4'hF; in_lst = 4'hF; out_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t1_rdy", in_rdy, t1_rdy[k]);
      if (k > 0) chk("t1_sel", out_sel, k - 1);
      step();
    end
    in_vld = 4'h0;
    @(negedge clk);
    chk("t1_sel_last", out_sel, 0);
    step();

    // 2: ch1 three-beat packet while others valid; next grant goes to ch2
    in_vld = 4'hF; in_lst = 4'b1101; dat[1] = 16'h2001;
    @(negedge clk); chk("t2_rdy_a", in_rdy, 4'b0010);
    step();
    dat[1] = 16'h2002;
    @(negedge clk); chk("t2_rdy_b", in_rdy, 4'b0010); chk("t2_sel_a", out_sel, 1); chk("t2_lst_a", out_lst, 0);
    step();
    dat[1] = 16'h2003; in_lst = 4'hF;
    @(negedge clk); chk("t2_rdy_c", in_rdy, 4'b0010); chk("t2_sel_b", out_sel, 1); chk("t2_lst_b", out_lst, 0);
    step();
    @(negedge clk); chk("t2_rdy_d", in_rdy, 4'b0100); chk("t2_sel_c", out_sel, 1); chk("t2_lst_c", out_lst, 1);
    chk("t2_dat_c", out_dat, 16'h2003);
    step();
    in_vld = 4'h0;
    @(negedge clk); chk("t2_sel_d", out_sel, 2);
    step();

    // 3: back-pressure holds A5A5 for four cycles, then resumes
    in_vld = 4'hF; in_lst = 4'hF; dat[3] = 16'hA5A5;
    @(negedge clk); chk("t3_rdy_a", in_rdy, 4'b1000);
    step();
    out_rdy = 1'b0; dat[3] = 16'h3333;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t3_hold_vld", out_vld, 1);
      chk("t3_hold_dat", out_dat, 16'hA5A5);
      chk("t3_hold_rdy", in_rdy, 4'b0000);
      step();
    end
    out_rdy = 1'b1;
    @(negedge clk); chk("t3_rdy_b", in_rdy, 4'b0001); chk("t3_dat_b", out_dat, 16'hA5A5);
    step();
    in_vld = 4'h0;
    @(negedge clk); chk("t3_sel_c", out_sel, 0); chk("t3_dat_c", out_dat, 16'h1000);
    step();

    // 4: pointer at 3 with only ch0 valid, then wrap to 1
    in_vld = 4'b0100;
    @(negedge clk); chk("t4_rdy_a", in_rdy, 4'b0100);
    step();
    in_vld = 4'b0001;
    @(negedge clk); chk("t4_rdy_b", in_rdy, 4'b0001);
    step();
    in_vld = 4'hF;
    @(negedge clk); chk("t4_rdy_c", in_rdy, 4'b0010);
    step();
    in_vld = 4'h0;
    step();

    // 5: ch2 owns the grant and goes idle; ch0 must not be served
    in_vld = 4'b0100; in_lst = 4'b0000; dat[2] = 16'h5002;
    @(negedge clk); chk("t5_rdy_a", in_rdy, 4'b0100);
    step();
    in_vld = 4'b0001; in_lst = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t5_stall_rdy", in_rdy, 4'b0000);
      chk("t5_stall_vld", out_vld, (k == 0) ? 1 : 0);
      step();
    end
    in_vld = 4'b0101; dat[2] = 16'h5003;
    @(negedge clk); chk("t5_rdy_b", in_rdy, 4'b0100);
    step();
    in_vld = 4'b0001;
    @(negedge clk); chk("t5_rdy_c", in_rdy, 4'b0001); chk("t5_sel", out_sel, 2); chk("t5_dat", out_dat, 16'h5003);
    step();
    in_vld = 4'h0;
    step();

    // 6: reset in the middle of a packet
    in_vld = 4'b0010; in_lst = 4'b0000;
    @(negedge clk); chk("t6_rdy_a", in_rdy, 4'b0010);
    step();
    rst = 1'b1; in_vld = 4'h0; in_lst = 4'hF;
    #1;
    chk("t6_rst_vld", out_vld, 0);
    chk("t6_rst_sel", out_sel, 0);
    chk("t6_rst_rdy", in_rdy, 4'b0000);
    step();
    rst = 1'b0;
    in_vld = 4'hF;
    @(negedge clk); chk("t6_rdy_b", in_rdy, 4'b0001);
    step();
    in_vld = 4'h0;
    step();

    // Randomized traffic; sources hold each beat until it is accepted
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      acc = in_vld & in_rdy;
      step();
      for (int i = 0; i < 4; i++) begin
        if (acc[i] || !in_vld[i]) begin
          in_vld[i] = ($urandom % 4) != 0;
          in_lst[i] = ($urandom % 3) != 0;
          dat[i]    = W'($urandom);
        end
      end
      out_rdy = ($urandom % 4) != 0;
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
